memory_responder: RTL and testbench

Responder end of `memory_bus`: accepts read and write dispatches from the `cpu` initiator and services them against an internal block-RAM data memory. Sits between `cpu` and on-chip RAM in the console top level. Provides a busy/valid handshake back to the initiator. It has a fixed, parameterised read latency and single-cycle write throughput.

---
 rtl/memory_responder.sv | 138 +++++++++++++
 tb/tb_memory_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// memory_responder
// Responder end of the memory bus. Services read and write dispatches from
// the cpu against an internal block RAM. A busy/valid handshake goes back
// to the initiator. Reads take a fixed READ_LATENCY; writes sustain one
// per cycle.
//
// State      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | ready; writes complete here, a read accept leaves for READ_WAIT
// READ_WAIT  | read in flight; busy high while the latency counter runs down
//
// Every output comes straight from a flop, so no combinational path runs
// from the bus inputs to the bus outputs.

module memory_responder #(
    parameter int    ADDR_WIDTH   = 16,
    parameter int    DATA_WIDTH   = 8,
    parameter int    DEPTH        = 4096,
    parameter int    READ_LATENCY = 2,
    parameter string INIT_FILE    = ""
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [ADDR_WIDTH-1:0] mem_bus_addr,
    input  logic [DATA_WIDTH-1:0] mem_bus_write_data,
    input  logic                  mem_bus_dispatch_read,
    input  logic                  mem_bus_dispatch_write,
    output logic [DATA_WIDTH-1:0] mem_bus_read_data,
    output logic                  mem_bus_read_valid,
    output logic                  mem_bus_write_done,
    output logic                  mem_bus_busy
);

    // INIT_FILE names the image that the FPGA build flow attaches to the
    // RAM. This logic neither reads nor clears memory contents.

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Legal latencies are 1..4. Anything outside that range is clamped so
    // the 2-bit counter can always hold the load value.
    localparam int RL = (READ_LATENCY < 1) ? 1 :
                        (READ_LATENCY > 4) ? 4 : READ_LATENCY;
    localparam logic [1:0] CNT_LOAD = 2'(RL - 1);

    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        READ_WAIT = 1'b1
    } state_t;

    state_t                  state;
    logic [1:0]              cnt;
    logic [IDX_W-1:0]        idx_q;
    logic                    in_range_q;
    logic [DATA_WIDTH-1:0]   ram_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    in_range;
    logic [IDX_W-1:0]        addr_idx;
    logic [IDX_W-1:0]        rd_idx;
    logic                    accept_write;
    logic                    accept_read;

    // Decode the request address and the accept qualifiers.
    always_comb begin
        in_range = ({1'b0, mem_bus_addr} < DEPTH_EXT);
        addr_idx = mem_bus_addr[IDX_W-1:0];

        // Reset wins over a dispatch on the same edge. A write takes
        // priority when both dispatches are high.
        accept_write = !rst_in && (state == IDLE) && mem_bus_dispatch_write;
        accept_read  = !rst_in && (state == IDLE) && mem_bus_dispatch_read
                       && !mem_bus_dispatch_write;

        // In IDLE the RAM is read at the live request address, so ram_q is
        // already valid one edge after accept. This lets READ_LATENCY = 1
        // work. While a read is in flight, the captured index keeps the
        // read port stable.
        rd_idx = (state == IDLE) ? addr_idx : idx_q;
    end

    // Block RAM with one synchronous write port and one synchronous read
    // port. It has no reset, so its contents survive rst_in.
    always_ff @(posedge clk_in) begin
        if (accept_write && in_range) begin
            mem[addr_idx] <= mem_bus_write_data;
        end
        ram_q <= mem[rd_idx];
    end

    // Control FSM and registered bus outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state              <= IDLE;
            cnt                <= '0;
            idx_q              <= '0;
            in_range_q         <= 1'b0;
            mem_bus_busy       <= 1'b0;
            mem_bus_read_valid <= 1'b0;
            mem_bus_write_done <= 1'b0;
            mem_bus_read_data  <= '0;
        end else begin
            mem_bus_read_valid <= 1'b0;
            mem_bus_write_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_write) begin
                        // Out-of-range writes are discarded at the RAM, but
                        // the initiator still receives its confirmation.
                        mem_bus_write_done <= 1'b1;
                    end else if (accept_read) begin
                        state        <= READ_WAIT;
                        mem_bus_busy <= 1'b1;
                        cnt          <= CNT_LOAD;
                        idx_q        <= addr_idx;
                        in_range_q   <= in_range;
                    end
                end
                READ_WAIT: begin
                    if (cnt == 2'd0) begin
                        state              <= IDLE;
                        mem_bus_busy       <= 1'b0;
                        mem_bus_read_valid <= 1'b1;
                        mem_bus_read_data  <= in_range_q ? ram_q : '0;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    mem_bus_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder with its default parameters
// (DEPTH = 4096, READ_LATENCY = 2). Inputs change 1 ns after a rising edge.
// Outputs are checked at that same point, so each check observes the cycle
// that follows the edge just taken.

module tb_memory_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [15:0] addr;
    logic [7:0]  write_data;
    logic        dispatch_read;
    logic        dispatch_write;
    logic [7:0]  read_data;
    logic        read_valid;
    logic        write_done;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    memory_responder #(
        .ADDR_WIDTH  (16),
        .DATA_WIDTH  (8),
        .DEPTH       (4096),
        .READ_LATENCY(2),
        .INIT_FILE   ("")
    ) dut (
        .clk_in                (clk_in),
        .rst_in                (rst_in),
        .mem_bus_addr          (addr),
        .mem_bus_write_data    (write_data),
        .mem_bus_dispatch_read (dispatch_read),
        .mem_bus_dispatch_write(dispatch_write),
        .mem_bus_read_data     (read_data),
        .mem_bus_read_valid    (read_valid),
        .mem_bus_write_done    (write_done),
        .mem_bus_busy          (busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        addr = a; write_data = d; dispatch_write = 1'b1; dispatch_read = 1'b0;
        tick();
        dispatch_write = 1'b0;
        check("write_done", 32'(write_done), 32'd1);
        check("write_busy", 32'(busy), 32'd0);
    endtask

    // A read at latency 2: busy for two cycles, then valid with data.
    task automatic do_read(input logic [15:0] a, input logic [7:0] exp_data);
        addr = a; dispatch_read = 1'b1; dispatch_write = 1'b0;
        tick();
        dispatch_read = 1'b0;
        check("rd_busy1", 32'(busy), 32'd1);
        check("rd_valid1", 32'(read_valid), 32'd0);
        tick();
        check("rd_busy2", 32'(busy), 32'd1);
        check("rd_valid2", 32'(read_valid), 32'd0);
        tick();
        check("rd_valid", 32'(read_valid), 32'd1);
        check("rd_data", 32'(read_data), 32'(exp_data));
        check("rd_busy_done", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_in = 1'b1; addr = '0; write_data = '0;
        dispatch_read = 1'b0; dispatch_write = 1'b0;
        tick(); tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(read_valid), 32'd0);
        check("rst_wdone", 32'(write_done), 32'd0);
        check("rst_data", 32'(read_data), 32'd0);
        rst_in = 1'b0;

        // Write, then read back; read_data holds after the valid pulse.
        do_write(16'h0123, 8'hA5);
        do_read(16'h0123, 8'hA5);
        tick();
        check("wr_rd_valid_drop", 32'(read_valid), 32'd0);
        check("wr_rd_data_hold", 32'(read_data), 32'hA5);
        check("wdone_one_cycle", 32'(write_done), 32'd0);

        // A write dispatched during busy is dropped.
        do_write(16'h0010, 8'h77);
        addr = 16'h0010; dispatch_read = 1'b1;
        tick();
        dispatch_read = 1'b0;
        addr = 16'h0010; write_data = 8'h99; dispatch_write = 1'b1;
        tick();
        dispatch_write = 1'b0;
        check("busy_drop_wdone", 32'(write_done), 32'd0);
        tick();
        check("busy_drop_valid", 32'(read_valid), 32'd1);
        check("busy_drop_data", 32'(read_data), 32'h77);
        tick();
        check("busy_drop_single", 32'(read_valid), 32'd0);
        check("busy_drop_wdone2", 32'(write_done), 32'd0);
        do_read(16'h0010, 8'h77);

        // Simultaneous dispatch: the write wins and the read is dropped.
        addr = 16'h0020; write_data = 8'h3C;
        dispatch_read = 1'b1; dispatch_write = 1'b1;
        tick();
        dispatch_read = 1'b0; dispatch_write = 1'b0;
        check("simul_wdone", 32'(write_done), 32'd1);
        check("simul_busy", 32'(busy), 32'd0);
        tick();
        check("simul_novalid1", 32'(read_valid), 32'd0);
        tick();
        check("simul_novalid2", 32'(read_valid), 32'd0);
        tick();
        check("simul_novalid3", 32'(read_valid), 32'd0);
        do_read(16'h0020, 8'h3C);

        // Out of range: 0x1000 aliases index 0 but must not modify it.
        do_write(16'h0000, 8'h11);
        do_write(16'h1000, 8'h5A);
        do_read(16'h1000, 8'h00);
        do_read(16'h0000, 8'h11);
        do_read(16'hFFFF, 8'h00);

        // Reset mid-read aborts the read and clears the outputs.
        addr = 16'h0123; dispatch_read = 1'b1;
        tick();
        dispatch_read = 1'b0;
        check("mid_busy", 32'(busy), 32'd1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(read_valid), 32'd0);
        check("mid_rst_wdone", 32'(write_done), 32'd0);
        check("mid_rst_data", 32'(read_data), 32'd0);
        tick();
        check("mid_novalid1", 32'(read_valid), 32'd0);
        tick();
        check("mid_novalid2", 32'(read_valid), 32'd0);
        do_read(16'h0123, 8'hA5);

        // Reset wins over a write dispatched on the same edge.
        rst_in = 1'b1; addr = 16'h0123; write_data = 8'hEE; dispatch_write = 1'b1;
        tick();
        rst_in = 1'b0; dispatch_write = 1'b0;
        check("rst_wins_wdone", 32'(write_done), 32'd0);
        do_read(16'h0123, 8'hA5);

        // Streaming writes: one accepted per cycle.
        for (int i = 0; i < 16; i++) begin
            do_write(16'(i), 8'(i * 3));
        end

        // Streaming reads: each new read is issued in the prior valid cycle.
        addr = 16'd0; dispatch_read = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            dispatch_read = 1'b0;
            tick();
            tick();
            check("stream_valid", 32'(read_valid), 32'd1);
            check("stream_data", 32'(read_data), 32'(8'(i * 3)));
            if (i < 15) begin
                addr = 16'(i + 1); dispatch_read = 1'b1;
            end
            tick();
            check("stream_busy_after", 32'(busy), (i < 15) ? 32'd1 : 32'd0);
        end
        check("stream_end_valid", 32'(read_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
